thermometer_stream_decoder: RTL and testbench

Clocked, two-stage pipelined decoder for thermometer-coded words. It accepts W-bit thermometer codes over a valid/ready handshake and returns the K-bit binary count of ones. It also flags malformed codes (bubbles) and keeps a saturating error tally. It sits downstream of the thermometer encoder path, e.g. between a switch/ADC-style thermometer source and the LED/binary display logic in `top`.

---
 rtl/thermo_pkg.sv | 16 +
 rtl/thermometer_popcount.sv | 17 +
 rtl/thermometer_stream_decoder.sv | 118 +++++++++++
 tb/tb_thermometer_stream_decoder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/thermo_pkg.sv
// Shared constants and the thermometer-legality helper for the stream decoder.
// Legal codes have their ones contiguous from bit 0 (all-zero and all-one included).
package thermo_pkg;

    localparam int THERMO_K = 3;
    localparam int THERMO_W = 2**THERMO_K - 1;

    localparam int                   ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

    // Caller zero-extends the code; the upper zeros keep the test exact for any W < 64.
    function automatic logic thermo_is_legal(input logic [63:0] code);
        return (code & (code + 64'd1)) == 64'd0;
    endfunction

endpackage

// File: rtl/thermometer_popcount.sv
// Combinational population count of a W-bit code into K bits.
module thermometer_popcount #(
    parameter int W = 7,
    parameter int K = 3
) (
    input  logic [W-1:0] code,
    output logic [K-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + K'(code[i]);
        end
    end

endmodule

// File: rtl/thermometer_stream_decoder.sv
// Two-stage valid/ready thermometer-to-binary decoder with bubble flag and error tally.
// Optional majority-vote bubble correction in stage 1 when THERMO_BUBBLE_FIX_EN is defined.
module thermometer_stream_decoder
    import thermo_pkg::*;
#(
    parameter int K = THERMO_K,
    parameter int W = 2**K - 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_code,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [K-1:0]         out_count,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 clr_err
);

    logic                 s1_valid_reg;
    logic [W-1:0]         s1_code_reg;
    logic                 s1_err_reg;
    logic                 out_valid_reg;
    logic [K-1:0]         out_count_reg;
    logic                 out_err_reg;
    logic [ERR_CNT_W-1:0] err_cnt_reg;
    logic [ERR_CNT_W-1:0] err_cnt_next;
    logic [W-1:0]         s1_code_next;
    logic [K-1:0]         s2_count_next;
    logic                 s1_err_next;
    logic                 s2_load;
    logic                 s1_load;

    assign s2_load  = !out_valid_reg || out_ready;
    assign s1_load  = !s1_valid_reg || s2_load;
    assign in_ready = s1_load;

    assign s1_err_next = !thermo_is_legal(64'(in_code));

`ifdef THERMO_BUBBLE_FIX_EN
    // Pad below with 1 and above with 0 so the edge bits vote like interior ones.
    logic [W+1:0] code_ext;
    assign code_ext = {1'b0, in_code, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_fix
            assign s1_code_next[gi] = (code_ext[gi]   & code_ext[gi+1]) |
                                      (code_ext[gi]   & code_ext[gi+2]) |
                                      (code_ext[gi+1] & code_ext[gi+2]);
        end
    endgenerate
`else
    assign s1_code_next = in_code;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_code_reg  <= '0;
            s1_err_reg   <= 1'b0;
        end else if (s1_load) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_code_reg <= s1_code_next;
                s1_err_reg  <= s1_err_next;
            end
        end
    end

    thermometer_popcount #(
        .W(W),
        .K(K)
    ) u_popcount (
        .code  (s1_code_reg),
        .count (s2_count_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_count_reg <= '0;
            out_err_reg   <= 1'b0;
        end else if (s2_load) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_count_reg <= s2_count_next;
                out_err_reg   <= s1_err_reg;
            end
        end
    end

    // Clear takes priority over a coincident erroneous delivery.
    always_comb begin
        err_cnt_next = err_cnt_reg;
        if (clr_err) begin
            err_cnt_next = '0;
        end else if (out_valid_reg && out_ready && out_err_reg && err_cnt_reg != ERR_CNT_MAX) begin
            err_cnt_next = err_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
        end else begin
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_count = out_count_reg;
    assign out_err   = out_err_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_thermometer_stream_decoder.sv
// Self-checking bench for thermometer_stream_decoder: vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_thermometer_stream_decoder;

    localparam int K = 3;
    localparam int W = 7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_code = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [K-1:0] out_count;
    logic         out_err;
    logic [7:0]   err_cnt;
    logic         clr_err = 1'b0;

    thermometer_stream_decoder #(.K(K), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_err   (out_err),
        .err_cnt   (err_cnt),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cnt;
        logic err;
    } exp_t;

    typedef struct {
        logic [W-1:0] code;
        int           cnt_raw;
        int           cnt_fix;
        logic         err;
    } vec_t;

    exp_t exp_q[$];
    int   exp_err_cnt = 0;
    int   checks = 0;
    int   fails = 0;
    int   out_fires = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: bubble-corrected or raw ones count, and legality as "code+1 is a power of two".
    function automatic int model_count(input logic [W-1:0] c);
        int n = 0;
`ifdef THERMO_BUBBLE_FIX_EN
        for (int i = 0; i < W; i++) begin
            int lo = (i == 0) ? 1 : int'(c[i-1]);
            int hi = (i == W-1) ? 0 : int'(c[i+1]);
            if (lo + int'(c[i]) + hi >= 2) n++;
        end
`else
        n = $countones(c);
`endif
        return n;
    endfunction

    function automatic logic model_err(input logic [W-1:0] c);
        logic [W:0] p = {1'b0, c} + 1'b1;
        return $countones(p) != 1;
    endfunction

    // One clock: check outputs mid-cycle against the model, update it, step past the edge.
    task automatic tick();
        logic fire;
        exp_t e;
        @(negedge clk);
        chk("err_cnt", int'(err_cnt), exp_err_cnt);
        fire = out_valid && out_ready;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("stale_word", 1, 0);
            end else begin
                e = exp_q[0];
                chk("out_count", int'(out_count), e.cnt);
                chk("out_err", int'(out_err), int'(e.err));
                if (fire) begin
                    void'(exp_q.pop_front());
                    out_fires++;
                end
            end
        end
        if (clr_err) exp_err_cnt = 0;
        else if (fire && e.err && exp_err_cnt < 255) exp_err_cnt++;
        if (in_valid && in_ready) begin
            exp_t n;
            n.cnt = model_count(in_code);
            n.err = model_err(in_code);
            exp_q.push_back(n);
        end
        $display("t=%0t in_v=%0b in_r=%0b code=%b out_v=%0b out_r=%0b cnt=%0d err=%0b err_cnt=%0d",
                 $time, in_valid, in_ready, in_code, out_valid, out_ready, out_count, out_err, err_cnt);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[8];

    initial begin
        int base;

        vecs[0] = '{7'b0000000, 0, 0, 1'b0};
        vecs[1] = '{7'b0000111, 3, 3, 1'b0};
        vecs[2] = '{7'b1111111, 7, 7, 1'b0};
        vecs[3] = '{7'b1000011, 3, 2, 1'b1};
        vecs[4] = '{7'b0101010, 3, 3, 1'b1};
        vecs[5] = '{7'b0000001, 1, 1, 1'b0};
        vecs[6] = '{7'b1110111, 6, 7, 1'b1};
        vecs[7] = '{7'b0010000, 1, 0, 1'b1};

        // Reset state
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table: one word at a time, two-edge latency, hand-derived results
        out_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            int req_cnt;
`ifdef THERMO_BUBBLE_FIX_EN
            req_cnt = vecs[v].cnt_fix;
`else
            req_cnt = vecs[v].cnt_raw;
`endif
            in_valid = 1'b1;
            in_code  = vecs[v].code;
            tick();
            in_valid = 1'b0;
            chk("lat_one_edge", int'(out_valid), 0);
            tick();
            chk("lat_two_edges", int'(out_valid), 1);
            chk("tbl_count", int'(out_count), req_cnt);
            chk("tbl_err", int'(out_err), int'(vecs[v].err));
            tick();
        end

        // Back-to-back legal codes at full rate
        base = out_fires;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] c8 = (8'd1 << i) - 8'd1;
            in_code = c8[W-1:0];
            chk("b2b_in_ready", int'(in_ready), 1);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("b2b_consecutive", out_fires - base, 8);

        // Backpressure: pipe fills to two words, then in_ready drops
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 7'b0000011;
        chk("bp_ready_empty", int'(in_ready), 1);
        tick();
        in_code = 7'b0011111;
        chk("bp_ready_one", int'(in_ready), 1);
        tick();
        in_code = 7'b0000001;
        for (int i = 0; i < 4; i++) begin
            chk("bp_ready_full", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("bp_drained", exp_q.size(), 0);

        // Saturation and clear
        in_valid = 1'b1;
        in_code  = 7'b1000011;
        for (int i = 0; i < 300; i++) tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("sat_255", int'(err_cnt), 255);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_zero", int'(err_cnt), 0);
        in_valid = 1'b1;
        in_code  = 7'b0100000;
        tick();
        in_valid = 1'b0;
        tick();
        chk("clr_race_valid", int'(out_valid & out_err), 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_race_zero", int'(err_cnt), 0);
        tick();

        // Asynchronous reset with two words in flight
        in_valid = 1'b1;
        in_code  = 7'b0001001;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("pre_rst_err_cnt", int'(err_cnt), 1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 7'b0000111;
        tick();
        in_code = 7'b0000001;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", int'(out_valid), 0);
        chk("rst_mid_err_cnt", int'(err_cnt), 0);
        exp_q.delete();
        exp_err_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_no_stale", int'(out_valid), 0);
            tick();
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(3) != 0);
            if ($urandom_range(1) == 0) begin
                logic [7:0] c8 = (8'd1 << $urandom_range(7)) - 8'd1;
                in_code = c8[W-1:0];
            end else begin
                in_code = W'($urandom);
            end
            out_ready = ($urandom_range(2) != 0);
            clr_err   = ($urandom_range(49) == 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_err   = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("rand_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
